// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer
//   Multi-cycle program-counter sequencer for the lab processor. It owns the
//   architectural PC. For each instruction it fetches from instruction memory
//   with a req/ack handshake, pulses instr_valid to the datapath, and waits
//   for ex_done. It then selects the next PC, which is either sequential or a
//   branch/jump target.
//
// Ports
//   clk, rst            system clock (rising edge); asynchronous active-low reset
//   start               begin or resume execution from IDLE/HALT
//   halt_req            external stop request, only acted on in NEXT
//   imem_req/addr/ack   instruction fetch handshake (addr == pc)
//   instr_valid         one-cycle pulse in the first EXEC cycle
//   ex_done             datapath finished; br_type/br_offset/flags valid
//   br_type, br_offset  branch kind and signed 26-bit byte offset
//   flag_z/n/c          condition flags
//   pc                  current PC
//   link_we, link_pc    link-register write pulse (call) and pc + INSTR_BYTES
//   busy, halted        status
//
// Optional build macro BRANCH_STATS_EN adds the saturating counters
// branch_cnt and taken_cnt. They are cleared on reset and on restart from
// HALT.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for start
// FETCH | imem_req high, waiting for imem_ack
// EXEC  | instruction issued, waiting for ex_done
// NEXT  | one cycle: pc update, link write, choose FETCH or HALT
// HALT  | stopped; start reloads RESET_PC and fetches

module pc_branch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] INSTR_BYTES = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic [2:0]  br_type,
    input  logic [25:0] br_offset,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_c,
    output logic [31:0] pc,
    output logic        link_we,
    output logic [31:0] link_pc,
    output logic        busy,
    output logic        halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] branch_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_NEXT  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] BR_SEQ  = 3'd0;
    localparam logic [2:0] BR_JUMP = 3'd1;
    localparam logic [2:0] BR_BZ   = 3'd2;
    localparam logic [2:0] BR_BNZ  = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BCY  = 3'd5;
    localparam logic [2:0] BR_CALL = 3'd6;
    localparam logic [2:0] BR_HALT = 3'd7;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        link_we_q, link_we_d;
    logic        imem_req_q, imem_req_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic [2:0]  bt_q, bt_d;
    logic [25:0] off_q, off_d;
    logic        z_q, z_d, n_q, n_d, c_q, c_d;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
`endif

    logic [31:0] tgt;
    logic [31:0] seq;
    logic        taken;

    // Branch decision uses the values latched on ex_done, so the datapath
    // may change br_type/flags while NEXT is in progress.
    assign tgt = pc_q + {{6{off_q[25]}}, off_q};
    assign seq = pc_q + INSTR_BYTES;

    always_comb begin
        taken = 1'b0;
        case (bt_q)
            BR_JUMP, BR_CALL: taken = 1'b1;
            BR_BZ:            taken = z_q;
            BR_BNZ:           taken = ~z_q;
            BR_BLTZ:          taken = n_q;
            BR_BCY:           taken = c_q;
            default:          taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = 1'b0;
        link_we_d     = 1'b0;
        bt_d          = bt_q;
        off_d         = off_q;
        z_d           = z_q;
        n_d           = n_q;
        c_d           = c_q;
`ifdef BRANCH_STATS_EN
        taken_cnt_d   = taken_cnt_q;
        branch_cnt_d  = branch_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    state_d       = S_EXEC;
                    instr_valid_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (ex_done) begin
                    state_d   = S_NEXT;
                    bt_d      = br_type;
                    off_d     = br_offset;
                    z_d       = flag_z;
                    n_d       = flag_n;
                    c_d       = flag_c;
                    // Registered so the pulse lines up with NEXT, while pc
                    // (and therefore link_pc) still holds the call address.
                    link_we_d = (br_type == BR_CALL);
                end
            end
            S_NEXT: begin
                pc_d    = taken ? tgt : seq;
                state_d = (bt_q == BR_HALT || halt_req) ? S_HALT : S_FETCH;
`ifdef BRANCH_STATS_EN
                if (bt_q != BR_SEQ && bt_q != BR_HALT && branch_cnt_q != 16'hFFFF)
                    branch_cnt_d = branch_cnt_q + 16'd1;
                if (taken && taken_cnt_q != 16'hFFFF)
                    taken_cnt_d = taken_cnt_q + 16'd1;
`endif
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
`ifdef BRANCH_STATS_EN
                    taken_cnt_d  = 16'd0;
                    branch_cnt_d = 16'd0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        imem_req_d = (state_d == S_FETCH);
        busy_d     = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_NEXT);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            link_we_q     <= 1'b0;
            imem_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            bt_q          <= BR_SEQ;
            off_q         <= 26'd0;
            z_q           <= 1'b0;
            n_q           <= 1'b0;
            c_q           <= 1'b0;
`ifdef BRANCH_STATS_EN
            taken_cnt_q   <= 16'd0;
            branch_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            link_we_q     <= link_we_d;
            imem_req_q    <= imem_req_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            bt_q          <= bt_d;
            off_q         <= off_d;
            z_q           <= z_d;
            n_q           <= n_d;
            c_q           <= c_d;
`ifdef BRANCH_STATS_EN
            taken_cnt_q   <= taken_cnt_d;
            branch_cnt_q  <= branch_cnt_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign link_pc     = seq;
    assign imem_req    = imem_req_q;
    assign instr_valid = instr_valid_q;
    assign link_we     = link_we_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
`ifdef BRANCH_STATS_EN
    assign taken_cnt   = taken_cnt_q;
    assign branch_cnt  = branch_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
module tb_pc_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        ex_done;
    logic [2:0]  br_type;
    logic [25:0] br_offset;
    logic        flag_z, flag_n, flag_c;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_pc;
    logic        busy;
    logic        halted;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] branch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_branch_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .INSTR_BYTES (32'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .ex_done     (ex_done),
        .br_type     (br_type),
        .br_offset   (br_offset),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_c      (flag_c),
        .pc          (pc),
        .link_we     (link_we),
        .link_pc     (link_pc),
        .busy        (busy),
        .halted      (halted)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt   (taken_cnt),
        .branch_cnt  (branch_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " imem_req"}, imem_req, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full instruction: fetch at addr, execute with the given branch
    // inputs, then expect pc == nxt after NEXT.
    task automatic do_instr(input string tag, input logic [31:0] addr,
                            input logic [2:0] bt, input logic [25:0] off,
                            input logic z, input logic n, input logic c,
                            input logic hreq, input int ack_dly, input int ex_dly,
                            input logic [31:0] nxt);
        wait_req(tag);
        chk({tag, " imem_addr"}, imem_addr, addr);
        chk({tag, " busy"}, busy, 32'd1);
        halt_req = hreq;
        repeat (ack_dly) begin
            @(negedge clk);
            chk({tag, " req held"}, imem_req, 32'd1);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk({tag, " instr_valid"}, instr_valid, 32'd1);
        chk({tag, " req dropped"}, imem_req, 32'd0);
        repeat (ex_dly) begin
            @(negedge clk);
            chk({tag, " iv one cycle"}, instr_valid, 32'd0);
            chk({tag, " exec busy"}, busy, 32'd1);
        end
        br_type   = bt;
        br_offset = off;
        flag_z    = z;
        flag_n    = n;
        flag_c    = c;
        ex_done   = 1'b1;
        @(negedge clk);
        ex_done   = 1'b0;
        // Scramble inputs so NEXT must use the latched copies.
        br_type   = 3'd0;
        br_offset = 26'h155_5555;
        flag_z    = ~z;
        flag_n    = ~n;
        flag_c    = ~c;
        chk({tag, " iv low in next"}, instr_valid, 32'd0);
        chk({tag, " link_we"}, link_we, {31'd0, bt == 3'd6});
        if (bt == 3'd6) chk({tag, " link_pc"}, link_pc, addr + 32'd4);
        chk({tag, " pc in next"}, pc, addr);
        @(negedge clk);
        halt_req = 1'b0;
        chk({tag, " link_we drop"}, link_we, 32'd0);
        chk({tag, " next pc"}, pc, nxt);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        halt_req  = 1'b0;
        imem_ack  = 1'b0;
        ex_done   = 1'b0;
        br_type   = 3'd0;
        br_offset = 26'd0;
        flag_z    = 1'b0;
        flag_n    = 1'b0;
        flag_c    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst pc", pc, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst link_pc", link_pc, 32'h4);
        chk("rst imem_req", imem_req, 32'd0);
        chk("rst busy", busy, 32'd0);
        chk("rst halted", halted, 32'd0);
        chk("rst instr_valid", instr_valid, 32'd0);
        chk("rst link_we", link_we, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle no req", imem_req, 32'd0);
        pulse_start();

        do_instr("seq0", 32'h0, 3'd0, 26'h0, 0, 0, 0, 0, 0, 0, 32'h4);
        start = 1'b1;
        do_instr("seq1 start busy", 32'h4, 3'd0, 26'h0, 0, 0, 0, 0, 1, 0, 32'h8);
        start = 1'b0;
        do_instr("jmp fwd", 32'h8, 3'd1, 26'h00000F8, 0, 0, 0, 0, 0, 0, 32'h100);
        do_instr("jmp -16", 32'h100, 3'd1, 26'h3FFFFF0, 0, 0, 0, 0, 0, 0, 32'h0F0);
        do_instr("jmp +10", 32'h0F0, 3'd1, 26'h0000010, 0, 0, 0, 0, 0, 0, 32'h100);
        do_instr("jmp +20", 32'h100, 3'd1, 26'h0000020, 0, 0, 0, 0, 0, 2, 32'h120);
        do_instr("bz t", 32'h120, 3'd2, 26'h0000040, 1, 0, 0, 0, 0, 0, 32'h160);
        do_instr("bz nt", 32'h160, 3'd2, 26'h0000040, 0, 1, 1, 0, 0, 0, 32'h164);
        do_instr("bnz t", 32'h164, 3'd3, 26'h0000010, 0, 0, 0, 0, 0, 0, 32'h174);
        do_instr("bnz nt", 32'h174, 3'd3, 26'h0000010, 1, 1, 1, 0, 0, 0, 32'h178);
        do_instr("bltz t", 32'h178, 3'd4, 26'h3FFFFF8, 0, 1, 0, 0, 0, 0, 32'h170);
        do_instr("bltz nt", 32'h170, 3'd4, 26'h3FFFFF8, 1, 0, 1, 0, 0, 0, 32'h174);
        do_instr("bcy nt", 32'h174, 3'd5, 26'h0000088, 1, 1, 0, 0, 0, 0, 32'h178);
        do_instr("bcy t", 32'h178, 3'd5, 26'h0000088, 0, 0, 1, 0, 0, 0, 32'h200);
        do_instr("call", 32'h200, 3'd6, 26'h0000040, 0, 0, 0, 0, 0, 0, 32'h240);
        do_instr("jmp neg", 32'h240, 3'd1, 26'h3FFFDBC, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        do_instr("seq wrap", 32'hFFFF_FFFC, 3'd0, 26'h0, 0, 0, 0, 0, 0, 0, 32'h0);

        do_instr("halt_req", 32'h0, 3'd0, 26'h0000040, 1, 1, 1, 1, 1, 1, 32'h4);
        chk("halt_req halted", halted, 32'd1);
        chk("halt_req busy", busy, 32'd0);
        chk("halt_req no fetch", imem_req, 32'd0);
        imem_ack = 1'b1;
        ex_done  = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        ex_done  = 1'b0;
        chk("halt ignores in", halted, 32'd1);
        chk("halt pc kept", pc, 32'h4);
        pulse_start();
        chk("restart halted", halted, 32'd0);

        do_instr("halt+req", 32'h0, 3'd7, 26'h0000040, 0, 0, 0, 1, 0, 0, 32'h4);
        chk("halt7 halted", halted, 32'd1);
        @(negedge clk);
        chk("halt7 stays", halted, 32'd1);
        pulse_start();

        do_instr("st jmp", 32'h0, 3'd1, 26'h0000010, 0, 0, 0, 0, 0, 0, 32'h10);
        do_instr("st bz nt", 32'h10, 3'd2, 26'h0000040, 0, 0, 0, 0, 0, 0, 32'h14);
        do_instr("st call", 32'h14, 3'd6, 26'h0000010, 0, 0, 0, 0, 0, 0, 32'h24);
`ifdef BRANCH_STATS_EN
        chk("branch_cnt", {16'd0, branch_cnt}, 32'd3);
        chk("taken_cnt", {16'd0, taken_cnt}, 32'd2);
`endif

        wait_req("abort");
        chk("abort addr", imem_addr, 32'h24);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        br_type   = 3'd6;
        br_offset = 26'h0000100;
        ex_done   = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("abort pc", pc, 32'h0);
        chk("abort imem_addr", imem_addr, 32'h0);
        chk("abort link_pc", link_pc, 32'h4);
        chk("abort link_we", link_we, 32'd0);
        chk("abort busy", busy, 32'd0);
        chk("abort iv", instr_valid, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("abort branch_cnt", {16'd0, branch_cnt}, 32'd0);
`endif
        @(negedge clk);
        chk("abort hold link_we", link_we, 32'd0);
        chk("abort hold pc", pc, 32'h0);
        ex_done = 1'b0;
        br_type = 3'd0;
        rst     = 1'b1;
        @(negedge clk);
        chk("abort idle", imem_req, 32'd0);
        pulse_start();
        do_instr("post abort", 32'h0, 3'd0, 26'h0, 0, 0, 0, 0, 0, 0, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
